// File: rtl/vetris_pkg.sv
// Shared types and constants for the vetris row-transfer datapath.
// Holds the responder FSM states and the playfield geometry defaults.
package vetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } rtu_state_t;

  localparam logic [4:0] LINE_STATUS_REG = 5'd9;

  localparam int ROW_W_DEF    = 10;
  localparam int NUM_ROWS_DEF = 20;
  localparam int DATA_W_DEF   = 32;
  localparam int TIMEOUT_DEF  = 15;
  localparam int IDX_W        = 5;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int num_rows);
    return 32'(idx) < 32'(num_rows);
  endfunction

endpackage

// File: rtl/line_status_reg.sv
// One bit per playfield row marking the row as full, written by row index.
// The row bits are zero-padded up to the register width.
module line_status_reg
  import vetris_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_bit,
  output logic [DATA_W-1:0] status
);

  logic [NUM_ROWS-1:0] rows;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (32'(wr_idx) == 32'(r)) begin
          rows[r] <= wr_bit;
        end
      end
    end
  end

  assign status = {{(DATA_W-NUM_ROWS){1'b0}}, rows};

endmodule

// File: rtl/row_transfer_unit.sv
// EX-stage responder for getRow/sendRow: runs the board memory handshake,
// returns getRow data for writeback and keeps the line-status word current.
module row_transfer_unit
  import vetris_pkg::*;
#(
  parameter int ROW_W    = ROW_W_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_get,
  input  logic              req_send,
  input  logic [4:0]        req_row_idx,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              busy,
  output logic              board_req,
  output logic              board_we,
  output logic [4:0]        board_addr,
  output logic [ROW_W-1:0]  board_wdata,
  input  logic              board_ack,
  input  logic [ROW_W-1:0]  board_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] line_status,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  rtu_state_t         state, next_state;
  logic               op_get;
  logic [4:0]         idx_q;
  logic [4:0]         rd_q;
  logic [ROW_W-1:0]   wdata_q;
  logic [ROW_W-1:0]   rdata_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_q;
  logic               accept;
  logic               idx_bad;
  logic               timeout_hit;
  logic               ls_wr;
  logic               unused_wdata_hi;

  assign unused_wdata_hi = ^req_wdata[DATA_W-1:ROW_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_get   <= 1'b0;
      idx_q    <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (accept) begin
            // A simultaneous get+send is resolved as a get and flagged.
            op_get  <= req_get;
            idx_q   <= req_row_idx;
            rd_q    <= req_rd;
            wdata_q <= req_wdata[ROW_W-1:0];
            rdata_q <= '0;
            if (idx_bad || (req_get && req_send)) begin
              err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (board_ack && op_get) begin
            rdata_q <= board_rdata;
          end
          if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    idx_bad     = !idx_in_range(req_row_idx, NUM_ROWS);
    timeout_hit = 1'b0;
    ls_wr       = 1'b0;
    busy        = 1'b1;
    board_req   = 1'b0;
    wb_valid    = 1'b0;
    case (state)
      IDLE: begin
        accept = req_valid && (req_get || req_send);
        busy   = accept;
        if (accept) begin
          next_state = idx_bad ? DONE : REQ;
        end
      end
      REQ: begin
        board_req  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        board_req   = 1'b1;
        timeout_hit = !board_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
        ls_wr       = board_ack && !op_get;
        if (board_ack || timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        wb_valid   = op_get;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign board_we    = !op_get;
  assign board_addr  = idx_q;
  assign board_wdata = wdata_q;
  assign wb_rd       = rd_q;
  assign wb_data     = {{(DATA_W-ROW_W){1'b0}}, rdata_q};
  assign err         = err_q;

  line_status_reg #(
    .NUM_ROWS(NUM_ROWS),
    .DATA_W  (DATA_W)
  ) u_line_status (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (ls_wr),
    .wr_idx(idx_q),
    .wr_bit(&wdata_q),
    .status(line_status)
  );

endmodule
